movegen_board_store: RTL and testbench

MOVEGEN_BOARD_STORE -- requirements
Module: movegen_board_store

---
 rtl/movegen_board_store_if.sv | 29 ++
 rtl/movegen_board_store.sv | 102 ++++++++++
 tb/tb_movegen_board_store.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/movegen_board_store_if.sv
// Position-load stream, lookup request/response and status bundle for movegen_board_store.
interface movegen_board_store_if #(
    parameter int unsigned PIECE_W = 4,
    parameter int unsigned NPORTS  = 2,
    parameter int unsigned CNT_W   = 16
);
    logic                        in_pos_valid;
    logic [PIECE_W-1:0]          in_pos_data;
    logic                        in_pos_sop;
    logic [NPORTS-1:0]           lookup_valid;
    logic [8*NPORTS-1:0]         lookup_rankfile;
    logic [NPORTS-1:0]           out_valid;
    logic [PIECE_W*NPORTS-1:0]   out_piece;
    logic [NPORTS-1:0]           out_offboard;
    logic                        pos_commit;
    logic                        pos_loaded;
    logic [CNT_W-1:0]            pos_count;
    logic                        load_err;

    modport master (
        output in_pos_valid, in_pos_data, in_pos_sop, lookup_valid, lookup_rankfile,
        input  out_valid, out_piece, out_offboard, pos_commit, pos_loaded, pos_count, load_err
    );

    modport slave (
        input  in_pos_valid, in_pos_data, in_pos_sop, lookup_valid, lookup_rankfile,
        output out_valid, out_piece, out_offboard, pos_commit, pos_loaded, pos_count, load_err
    );
endinterface

// File: rtl/movegen_board_store.sv
// Double-buffered 8x8 board store: a streamed board loads into the shadow bank and swaps in
// atomically after square 63; independent 1-cycle 0x88 lookup ports read the active bank.
module movegen_board_store #(
    parameter int unsigned PIECE_W = 4,
    parameter int unsigned NPORTS  = 2,
    parameter int unsigned CNT_W   = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    movegen_board_store_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StLoad, StDrain} state_e;

    state_e                     r_state;
    logic [5:0]                 r_idx;
    logic                       r_active;
    logic [PIECE_W-1:0]         r_bank [2][64];
    logic                       r_commit;
    logic                       r_err;
    logic                       r_loaded;
    logic [CNT_W-1:0]           r_count;
    logic [NPORTS-1:0]          r_out_valid;
    logic [NPORTS-1:0]          r_out_off;
    logic [PIECE_W*NPORTS-1:0]  r_out_piece;
    logic                       w_shadow;

    assign w_shadow = ~r_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_idx    <= '0;
            r_active <= 1'b0;
            r_commit <= 1'b0;
            r_err    <= 1'b0;
            r_loaded <= 1'b0;
            r_count  <= '0;
            for (int b = 0; b < 2; b++) begin
                for (int s = 0; s < 64; s++) begin
                    r_bank[b][s] <= '0;
                end
            end
        end else begin
            r_commit <= 1'b0;
            r_err    <= 1'b0;
            if (bus.in_pos_valid) begin
                if (bus.in_pos_sop) begin
                    // A sop while loading abandons the partial board; active bank untouched.
                    r_bank[w_shadow][0] <= bus.in_pos_data;
                    r_idx               <= 6'd1;
                    r_state             <= StLoad;
                    if (r_state == StLoad) r_err <= 1'b1;
                end else if (r_state == StLoad) begin
                    r_bank[w_shadow][r_idx] <= bus.in_pos_data;
                    if (r_idx == 6'd63) begin
                        r_active <= ~r_active;
                        r_commit <= 1'b1;
                        r_count  <= r_count + CNT_W'(1);
                        r_loaded <= 1'b1;
                        r_idx    <= '0;
                        r_state  <= StDrain;
                    end else begin
                        r_idx <= r_idx + 6'd1;
                    end
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    // Reads use the pre-edge r_active, so a lookup on the swap edge sees the old board.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= '0;
            r_out_off   <= '0;
            r_out_piece <= '0;
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                r_out_valid[p] <= bus.lookup_valid[p];
                r_out_off[p]   <= bus.lookup_valid[p] &
                                  (bus.lookup_rankfile[8*p+7] | bus.lookup_rankfile[8*p+3]);
                if (bus.lookup_valid[p] &&
                    !(bus.lookup_rankfile[8*p+7] || bus.lookup_rankfile[8*p+3])) begin
                    r_out_piece[PIECE_W*p +: PIECE_W] <=
                        r_bank[r_active][{bus.lookup_rankfile[8*p+4 +: 3],
                                          bus.lookup_rankfile[8*p +: 3]}];
                end else begin
                    r_out_piece[PIECE_W*p +: PIECE_W] <= '0;
                end
            end
        end
    end

    assign bus.out_valid    = r_out_valid;
    assign bus.out_offboard = r_out_off;
    assign bus.out_piece    = r_out_piece;
    assign bus.pos_commit   = r_commit;
    assign bus.pos_loaded   = r_loaded;
    assign bus.pos_count    = r_count;
    assign bus.load_err     = r_err;
endmodule

// File: tb/tb_movegen_board_store.sv
// Directed bench for movegen_board_store: load, restart, overrun, off-board and swap-edge lookups.
module tb_movegen_board_store;
    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;
    int   n_commit;
    int   n_err;
    int   c0;
    int   e0;

    movegen_board_store_if #(.PIECE_W(4), .NPORTS(2), .CNT_W(16)) u_bus ();

    movegen_board_store #(.PIECE_W(4), .NPORTS(2), .CNT_W(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (u_bus.pos_commit) n_commit++;
        if (u_bus.load_err) n_err++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic beat(input logic [3:0] d, input logic s);
        @(negedge clk);
        u_bus.in_pos_valid = 1'b1;
        u_bus.in_pos_data  = d;
        u_bus.in_pos_sop   = s;
        @(posedge clk);
        #1;
        u_bus.in_pos_valid = 1'b0;
        u_bus.in_pos_sop   = 1'b0;
    endtask

    task automatic lookup(input int p, input logic [7:0] rf);
        @(negedge clk);
        u_bus.lookup_valid              = '0;
        u_bus.lookup_valid[p]           = 1'b1;
        u_bus.lookup_rankfile[8*p +: 8] = rf;
        @(posedge clk);
        #1;
        u_bus.lookup_valid = '0;
    endtask

    initial begin
        n_pass = 0; n_total = 0; n_commit = 0; n_err = 0;
        rst_n = 1'b0;
        u_bus.in_pos_valid = 1'b0; u_bus.in_pos_data = '0; u_bus.in_pos_sop = 1'b0;
        u_bus.lookup_valid = '0;   u_bus.lookup_rankfile = '0;
        #1;
        check("rst_out_valid", u_bus.out_valid, 0);
        check("rst_out_piece", u_bus.out_piece, 0);
        check("rst_count",     u_bus.pos_count, 0);
        check("rst_loaded",    u_bus.pos_loaded, 0);
        check("rst_flags",     {u_bus.pos_commit, u_bus.load_err, u_bus.out_offboard}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        lookup(0, 8'h00);
        check("empty_valid", u_bus.out_valid, 2'b01);
        check("empty_piece", u_bus.out_piece[3:0], 0);
        check("empty_off",   u_bus.out_offboard, 0);
        @(posedge clk); #1;
        check("idle_valid0", u_bus.out_valid, 0);

        // Board 1: data = index mod 16.
        c0 = n_commit; e0 = n_err;
        for (int i = 0; i < 64; i++) beat(4'(i % 16), i == 0);
        check("b1_commit_pulse", u_bus.pos_commit, 1);
        check("b1_count",        u_bus.pos_count, 1);
        check("b1_loaded",       u_bus.pos_loaded, 1);
        lookup(0, 8'h37);
        check("b1_sq31", u_bus.out_piece[3:0], 4'hF);
        check("b1_commit_end", u_bus.pos_commit, 0);
        lookup(1, 8'h77);
        check("b1_sq63_p1", u_bus.out_piece[7:4], 4'hF);
        lookup(0, 8'h23);
        check("b1_sq19", u_bus.out_piece[3:0], 4'h3);
        lookup(0, 8'h07);
        check("b1_sq7", u_bus.out_piece[3:0], 4'h7);
        check("b1_ncommit", n_commit - c0, 1);
        check("b1_nerr",    n_err - e0, 0);

        // Aborted partial board then a full board of 0x3.
        c0 = n_commit; e0 = n_err;
        for (int i = 0; i < 20; i++) beat(4'h5, i == 0);
        lookup(0, 8'h77);
        check("partial_no_effect", u_bus.out_piece[3:0], 4'hF);
        for (int i = 0; i < 64; i++) beat(4'h3, i == 0);
        for (int r = 0; r < 8; r++) begin
            for (int f = 0; f < 8; f++) begin
                lookup(r % 2, {1'b0, 3'(r), 1'b0, 3'(f)});
                check("b2_square", (r % 2 == 0) ? u_bus.out_piece[3:0] : u_bus.out_piece[7:4],
                      4'h3);
            end
        end
        check("b2_nerr",    n_err - e0, 1);
        check("b2_ncommit", n_commit - c0, 1);
        check("b2_count",   u_bus.pos_count, 2);

        // Overrun beat in DRAIN.
        beat(4'h9, 1'b0);
        check("ovr_err",   u_bus.load_err, 1);
        check("ovr_count", u_bus.pos_count, 2);
        lookup(0, 8'h00);
        check("ovr_sq0", u_bus.out_piece[3:0], 4'h3);
        lookup(0, 8'h77);
        check("ovr_sq63", u_bus.out_piece[3:0], 4'h3);

        // Off-board on both ports together.
        @(negedge clk);
        u_bus.lookup_valid = 2'b11;
        u_bus.lookup_rankfile = {8'h80, 8'h08};
        @(posedge clk); #1;
        u_bus.lookup_valid = '0;
        check("off_valid", u_bus.out_valid, 2'b11);
        check("off_flags", u_bus.out_offboard, 2'b11);
        check("off_piece", u_bus.out_piece, 0);

        // Board B (0xA) final beat coincides with a lookup of square 0.
        for (int i = 0; i < 63; i++) beat(4'hA, i == 0);
        @(negedge clk);
        u_bus.in_pos_valid = 1'b1; u_bus.in_pos_data = 4'hA; u_bus.in_pos_sop = 1'b0;
        u_bus.lookup_valid = 2'b01; u_bus.lookup_rankfile = 16'h0000;
        @(posedge clk); #1;
        u_bus.in_pos_valid = 1'b0; u_bus.lookup_valid = '0;
        check("swap_old_board", u_bus.out_piece[3:0], 4'h3);
        check("swap_commit",    u_bus.pos_commit, 1);
        @(negedge clk);
        u_bus.lookup_valid = 2'b11; u_bus.lookup_rankfile = 16'h0000;
        @(posedge clk); #1;
        u_bus.lookup_valid = '0;
        check("swap_new_both", u_bus.out_piece, 8'hAA);
        check("swap_count",    u_bus.pos_count, 3);

        // Reset in the middle of a load.
        c0 = n_commit;
        for (int i = 0; i < 10; i++) beat(4'h1, i == 0);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("mid_rst_count",  u_bus.pos_count, 0);
        check("mid_rst_loaded", u_bus.pos_loaded, 0);
        @(negedge clk);
        rst_n = 1'b1;
        lookup(0, 8'h00);
        check("mid_rst_sq0", u_bus.out_piece[3:0], 0);
        lookup(1, 8'h77);
        check("mid_rst_sq63", u_bus.out_piece[7:4], 0);
        check("mid_rst_nocommit", n_commit - c0, 0);
        beat(4'h2, 1'b0);
        check("idle_drop_err", u_bus.load_err, 1);
        check("idle_drop_count", u_bus.pos_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
